// File: rtl/i2c_slv_pkg.sv
// ----------------------------------------------------------------------------
// i2c_slv_pkg
//
// Shared types and constants for the I2C target (responder) block.
//   - i2c_slv_state_e : protocol FSM states
//   - I2C_ACK/I2C_NACK: SDA levels for the acknowledge slot
//   - BITCNT_W        : width of the bit counter (must be able to hold 8)
// ----------------------------------------------------------------------------
package i2c_slv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK
  } i2c_slv_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam int BITCNT_W = 4;

endpackage

// File: rtl/i2c_slv_filter.sv
// ----------------------------------------------------------------------------
// i2c_slv_filter
//
// Brings one asynchronous bus line (SCL or SDA) into the pclk domain through a
// two-flop synchroniser. When the macro I2C_SLV_GLITCH_FILTER_EN is defined, a
// stability filter follows the synchroniser: the output only takes a new level
// once FILT_LEN consecutive synchronised samples agree on it.
//
// Ports
//   clk_i   in  1  system clock
//   reset_i in  1  synchronous active-high reset (output resets to idle-high)
//   line_i  in  1  raw bus level
//   line_o  out 1  synchronised (and optionally filtered) level
// ----------------------------------------------------------------------------
module i2c_slv_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic line_i,
  output logic line_o
);

  logic meta_q;
  logic sync_q;

  // Two-flop synchroniser. Both stages reset high because an idle I2C bus
  // floats high; resetting low would fake an edge right after reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
    end
  end

`ifdef I2C_SLV_GLITCH_FILTER_EN
  localparam int CNT_W = $clog2(FILT_LEN + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             filt_q;

  // Stability filter: count how long the synchronised level has disagreed
  // with the filtered level, and only accept it after FILT_LEN samples in a
  // row. Any return to the current level restarts the count, so pulses
  // shorter than FILT_LEN cycles never reach the output.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else if (sync_q == filt_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_W'(FILT_LEN - 1)) begin
      filt_q <= sync_q;
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign line_o = filt_q;
`else
  localparam int unusedFiltLen = FILT_LEN;

  assign line_o = sync_q;
`endif

endmodule

// File: rtl/i2c_slave_responder.sv
// ----------------------------------------------------------------------------
// i2c_slave_responder
//
// I2C target that answers a controller on an open-drain SCL/SDA bus. It never
// drives SCL; it only pulls SDA low through sda_o/sda_oen. A MEM_DEPTH x 8
// register file is reached through an auto-incrementing pointer: the first
// byte of a write sets the pointer, later bytes are stored, and reads return
// bytes starting at the pointer. The pointer wraps at MEM_DEPTH.
//
// Parameters
//   SLAVE_ADDR  7-bit address this target responds to
//   MEM_DEPTH   register-file size in bytes (power of 2, 2..256)
//   FILT_LEN    glitch-filter length, used only with I2C_SLV_GLITCH_FILTER_EN
//
// Ports
//   pclk      in   1  system clock (at least 16x the SCL frequency)
//   areset    in   1  synchronous active-high reset
//   scl_i     in   1  bus SCL level
//   sda_i     in   1  bus SDA level
//   sda_o     out  1  constant 0 (open drain)
//   sda_oen   out  1  1 pulls SDA low, 0 releases it
//   busy      out  1  high from an addressed START until STOP
//   rx_valid  out  1  one-cycle pulse when a data byte is stored
//   rx_ptr    out  $clog2(MEM_DEPTH)  index of the stored byte
//   rx_data   out  8  stored byte
//
// Build option
//   I2C_SLV_GLITCH_FILTER_EN : adds a FILT_LEN-cycle stability filter to both
//   bus lines after the synchroniser.
// ----------------------------------------------------------------------------
module i2c_slave_responder
  import i2c_slv_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         MEM_DEPTH  = 16,
  parameter int         FILT_LEN   = 3
) (
  input  logic                         pclk,
  input  logic                         areset,
  input  logic                         scl_i,
  input  logic                         sda_i,
  output logic                         sda_o,
  output logic                         sda_oen,
  output logic                         busy,
  output logic                         rx_valid,
  output logic [$clog2(MEM_DEPTH)-1:0] rx_ptr,
  output logic [7:0]                   rx_data
);

  localparam int PTR_W = $clog2(MEM_DEPTH);

  logic sclFilt;
  logic sdaFilt;

  i2c_slv_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_scl_filter (
    .clk_i   (pclk),
    .reset_i (areset),
    .line_i  (scl_i),
    .line_o  (sclFilt)
  );

  i2c_slv_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_sda_filter (
    .clk_i   (pclk),
    .reset_i (areset),
    .line_i  (sda_i),
    .line_o  (sdaFilt)
  );

  i2c_slv_state_e       state_q;
  logic [BITCNT_W-1:0]  bitCnt_q;
  logic [6:0]           shift_q;
  logic [6:0]           txBits_q;
  logic [PTR_W-1:0]     ptr_q;
  logic [7:0]           mem_q [MEM_DEPTH];
  logic                 rw_q;
  logic                 firstByte_q;
  logic                 ackPhase_q;
  logic                 sdaOen_q;
  logic                 busy_q;
  logic                 rxValid_q;
  logic [PTR_W-1:0]     rxPtr_q;
  logic [7:0]           rxData_q;
  logic                 sclPrev_q;
  logic                 sdaPrev_q;

  logic                 sclRise;
  logic                 sclFall;
  logic                 condEn;
  logic                 startDet;
  logic                 stopDet;
  logic [7:0]           shift_d;

  // Bus event detection against the previous synchronised sample. START and
  // STOP are ignored while this target is pulling SDA itself, so its own ACK
  // or data-0 drive can never be mistaken for a controller bus condition.
  assign sclRise  = sclFilt & ~sclPrev_q;
  assign sclFall  = ~sclFilt & sclPrev_q;
  assign condEn   = ~sdaOen_q;
  assign startDet = condEn & sclFilt & sclPrev_q & sdaPrev_q & ~sdaFilt;
  assign stopDet  = condEn & sclFilt & sclPrev_q & ~sdaPrev_q & sdaFilt;

  // The byte as it will look once the bit currently on SDA is shifted in,
  // MSB first. Used on the 8th rising edge to act on the complete byte.
  assign shift_d = {shift_q, sdaFilt};

  // Protocol FSM with registered outputs. STOP wins over START, and both
  // override whatever the FSM was doing. Otherwise data bits are sampled on
  // SCL rise and SDA is only ever changed on SCL fall, so the new level is
  // on the bus one pclk after the fall is detected.
  always_ff @(posedge pclk) begin
    if (areset) begin
      state_q     <= IDLE;
      bitCnt_q    <= '0;
      shift_q     <= '0;
      txBits_q    <= '0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      firstByte_q <= 1'b0;
      ackPhase_q  <= 1'b0;
      sdaOen_q    <= 1'b0;
      busy_q      <= 1'b0;
      rxValid_q   <= 1'b0;
      rxPtr_q     <= '0;
      rxData_q    <= '0;
      sclPrev_q   <= 1'b1;
      sdaPrev_q   <= 1'b1;
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      sclPrev_q <= sclFilt;
      sdaPrev_q <= sdaFilt;
      rxValid_q <= 1'b0;

      if (stopDet) begin
        state_q  <= IDLE;
        sdaOen_q <= 1'b0;
        busy_q   <= 1'b0;
      end else if (startDet) begin
        state_q  <= ADDR;
        bitCnt_q <= '0;
        sdaOen_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
          end

          // Collect the address byte; only a matching address is answered.
          ADDR: begin
            if (sclRise) begin
              shift_q <= shift_d[6:0];
              if (bitCnt_q == BITCNT_W'(7)) begin
                bitCnt_q <= '0;
                if (shift_d[7:1] == SLAVE_ADDR) begin
                  state_q    <= ADDR_ACK;
                  busy_q     <= 1'b1;
                  rw_q       <= shift_d[0];
                  ackPhase_q <= 1'b0;
                end else begin
                  state_q <= IDLE;
                end
              end else begin
                bitCnt_q <= bitCnt_q + BITCNT_W'(1);
              end
            end
          end

          // First fall: pull SDA for the ACK. Second fall: leave the ACK slot
          // and either present the first read bit or get ready for writes.
          ADDR_ACK: begin
            if (sclFall) begin
              if (!ackPhase_q) begin
                sdaOen_q   <= ~I2C_ACK;
                ackPhase_q <= 1'b1;
              end else if (rw_q) begin
                txBits_q <= mem_q[ptr_q][6:0];
                sdaOen_q <= ~mem_q[ptr_q][7];
                bitCnt_q <= '0;
                state_q  <= RD_BYTE;
              end else begin
                sdaOen_q    <= 1'b0;
                firstByte_q <= 1'b1;
                bitCnt_q    <= '0;
                state_q     <= WR_BYTE;
              end
            end
          end

          // The first written byte loads the pointer (low bits only); every
          // later byte is stored and reported, with the pointer wrapping.
          WR_BYTE: begin
            if (sclRise) begin
              shift_q <= shift_d[6:0];
              if (bitCnt_q == BITCNT_W'(7)) begin
                bitCnt_q   <= '0;
                ackPhase_q <= 1'b0;
                state_q    <= WR_ACK;
                if (firstByte_q) begin
                  ptr_q       <= shift_d[PTR_W-1:0];
                  firstByte_q <= 1'b0;
                end else begin
                  mem_q[ptr_q] <= shift_d;
                  rxValid_q    <= 1'b1;
                  rxPtr_q      <= ptr_q;
                  rxData_q     <= shift_d;
                  ptr_q        <= ptr_q + PTR_W'(1);
                end
              end else begin
                bitCnt_q <= bitCnt_q + BITCNT_W'(1);
              end
            end
          end

          // Every written byte is acknowledged.
          WR_ACK: begin
            if (sclFall) begin
              if (!ackPhase_q) begin
                sdaOen_q   <= ~I2C_ACK;
                ackPhase_q <= 1'b1;
              end else begin
                sdaOen_q <= 1'b0;
                state_q  <= WR_BYTE;
              end
            end
          end

          // Count the controller's sampling edges; after the 8th one, release
          // SDA for the controller's ACK and advance the pointer.
          RD_BYTE: begin
            if (sclRise) begin
              bitCnt_q <= bitCnt_q + BITCNT_W'(1);
            end else if (sclFall) begin
              if (bitCnt_q == BITCNT_W'(8)) begin
                sdaOen_q   <= 1'b0;
                ptr_q      <= ptr_q + PTR_W'(1);
                ackPhase_q <= 1'b0;
                state_q    <= RD_ACK;
              end else begin
                sdaOen_q <= ~txBits_q[6];
                txBits_q <= {txBits_q[5:0], 1'b0};
              end
            end
          end

          // A controller ACK asks for another byte, presented on the next
          // fall. A NACK ends the read; SDA stays released until START/STOP.
          RD_ACK: begin
            if (sclRise) begin
              if (sdaFilt == I2C_NACK) begin
                state_q <= IDLE;
              end else begin
                ackPhase_q <= 1'b1;
              end
            end else if (sclFall && ackPhase_q) begin
              txBits_q <= mem_q[ptr_q][6:0];
              sdaOen_q <= ~mem_q[ptr_q][7];
              bitCnt_q <= '0;
              state_q  <= RD_BYTE;
            end
          end

          default: begin
            state_q  <= IDLE;
            sdaOen_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sda_o    = 1'b0;
  assign sda_oen  = sdaOen_q;
  assign busy     = busy_q;
  assign rx_valid = rxValid_q;
  assign rx_ptr   = rxPtr_q;
  assign rx_data  = rxData_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// ----------------------------------------------------------------------------
// tb_i2c_slave_responder
//
// Drives the I2C target as a bus controller (open-drain SDA resolved as a
// wired-AND with the target's pull) and compares responses with a simple
// register-file model: an array of bytes plus a wrapping pointer.
// Build option I2C_SLV_GLITCH_FILTER_EN selects the expected glitch result.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_slave_responder;

  localparam int         MEM_DEPTH = 16;
  localparam logic [6:0] OWN_ADDR  = 7'h50;
  localparam int         QTR       = 10;
  localparam int         HALF      = 20;

  logic       pclk   = 1'b0;
  logic       areset = 1'b1;
  logic       sclM   = 1'b1;
  logic       sdaM   = 1'b1;
  logic       sda_o;
  logic       sda_oen;
  logic       busy;
  logic       rx_valid;
  logic [3:0] rx_ptr;
  logic [7:0] rx_data;
  wire        sdaBus = sda_oen ? (sdaM & sda_o) : sdaM;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  logic [7:0]  refMem [MEM_DEPTH];
  int          refPtr;
  logic [7:0]  txQ [$];
  logic [11:0] rxSeen [$];
  logic [11:0] rxExp [$];
  int          rxReadIdx = 0;
  int          oenCycles = 0;

  i2c_slave_responder dut (
    .pclk     (pclk),
    .areset   (areset),
    .scl_i    (sclM),
    .sda_i    (sdaBus),
    .sda_o    (sda_o),
    .sda_oen  (sda_oen),
    .busy     (busy),
    .rx_valid (rx_valid),
    .rx_ptr   (rx_ptr),
    .rx_data  (rx_data)
  );

  always #5 pclk = ~pclk;

  // Record every stored-byte report and how long the target pulls SDA,
  // sampled on the falling pclk edge away from the DUT's update edge.
  always @(negedge pclk) begin
    if (rx_valid) rxSeen.push_back({rx_ptr, rx_data});
    if (sda_oen) oenCycles++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic sclVal, input logic sdaVal, input int cycles);
    sclM = sclVal;
    sdaM = sdaVal;
    repeat (cycles) @(negedge pclk);
  endtask

  task automatic busStart();
    applyStimulus(1'b0, 1'b1, QTR);
    applyStimulus(1'b1, 1'b1, HALF);
    applyStimulus(1'b1, 1'b0, HALF);
    applyStimulus(1'b0, 1'b0, QTR);
  endtask

  task automatic busStop();
    applyStimulus(1'b0, 1'b0, QTR);
    applyStimulus(1'b1, 1'b0, HALF);
    applyStimulus(1'b1, 1'b1, HALF);
  endtask

  task automatic writeBit(input logic b);
    applyStimulus(1'b0, b, QTR);
    applyStimulus(1'b1, b, HALF);
    applyStimulus(1'b0, b, QTR);
  endtask

  task automatic readBit(output logic b);
    applyStimulus(1'b0, 1'b1, QTR);
    applyStimulus(1'b1, 1'b1, HALF / 2);
    b = sdaBus;
    applyStimulus(1'b1, 1'b1, HALF / 2);
    applyStimulus(1'b0, 1'b1, QTR);
  endtask

  task automatic writeByte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) writeBit(d[i]);
    readBit(ack);
  endtask

  task automatic readByte(output logic [7:0] d, input logic masterAck);
    for (int i = 7; i >= 0; i--) readBit(d[i]);
    writeBit(masterAck);
  endtask

  // Same as writeByte, but bit number g (0 = MSB) carries a 1-pclk low
  // pulse on SCL in the middle of its high phase.
  task automatic writeByteGlitch(input logic [7:0] d, input int g);
    logic ack;
    for (int i = 0; i < 8; i++) begin
      if (i == g) begin
        applyStimulus(1'b0, d[7-i], QTR);
        applyStimulus(1'b1, d[7-i], 6);
        applyStimulus(1'b0, d[7-i], 1);
        applyStimulus(1'b1, d[7-i], HALF - 7);
        applyStimulus(1'b0, d[7-i], QTR);
      end else begin
        writeBit(d[7-i]);
      end
    end
    readBit(ack);
  endtask

  // Without filtering, the glitch adds a duplicate of bit g, so the target
  // stores the first eight bits of the lengthened sequence.
  function automatic logic [7:0] glitchByte(input logic [7:0] d, input int g);
    logic       bits [$];
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      bits.push_back(d[7-i]);
      if (i == g) bits.push_back(d[7-i]);
    end
    for (int i = 0; i < 8; i++) r[7-i] = bits[i];
    return r;
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < MEM_DEPTH; i++) refMem[i] = 8'h00;
    refPtr = 0;
  endfunction

  // Write transaction of txQ (pointer byte first) to address addr.
  task automatic writeTxn(input logic [6:0] addr);
    logic ack;
    logic addressed;
    addressed = (addr == OWN_ADDR);
    busStart();
    writeByte({addr, 1'b0}, ack);
    checkOutput("wr_addr_ack", 32'(ack), addressed ? 32'd0 : 32'd1);
    for (int k = 0; k < txQ.size(); k++) begin
      writeByte(txQ[k], ack);
      checkOutput("wr_byte_ack", 32'(ack), addressed ? 32'd0 : 32'd1);
    end
    checkOutput("wr_busy_before_stop", 32'(busy), 32'(addressed));
    busStop();
    checkOutput("wr_busy_after_stop", 32'(busy), 32'd0);
    if (addressed && txQ.size() > 0) begin
      refPtr = txQ[0] % MEM_DEPTH;
      for (int k = 1; k < txQ.size(); k++) begin
        refMem[refPtr] = txQ[k];
        rxExp.push_back({4'(refPtr), txQ[k]});
        refPtr = (refPtr + 1) % MEM_DEPTH;
      end
    end
  endtask

  // Pointer write, repeated START, read n bytes (last one NACKed), STOP.
  task automatic readTxn(input logic [7:0] ptrByte, input int n);
    logic       ack;
    logic [7:0] d;
    busStart();
    writeByte({OWN_ADDR, 1'b0}, ack);
    checkOutput("rd_addrw_ack", 32'(ack), 32'd0);
    writeByte(ptrByte, ack);
    checkOutput("rd_ptr_ack", 32'(ack), 32'd0);
    busStart();
    writeByte({OWN_ADDR, 1'b1}, ack);
    checkOutput("rd_addrr_ack", 32'(ack), 32'd0);
    refPtr = ptrByte % MEM_DEPTH;
    for (int k = 0; k < n; k++) begin
      readByte(d, (k == n - 1) ? 1'b1 : 1'b0);
      checkOutput("rd_data", 32'(d), 32'(refMem[refPtr]));
      refPtr = (refPtr + 1) % MEM_DEPTH;
    end
    checkOutput("rd_busy_before_stop", 32'(busy), 32'd1);
    busStop();
    checkOutput("rd_busy_after_stop", 32'(busy), 32'd0);
  endtask

  // Compare stored-byte reports since the last call with the model.
  task automatic checkRx();
    int n;
    n = rxSeen.size() - rxReadIdx;
    checkOutput("rx_count", 32'(n), 32'(rxExp.size()));
    for (int k = 0; k < rxExp.size() && k < n; k++) begin
      checkOutput("rx_entry", 32'(rxSeen[rxReadIdx + k]), 32'(rxExp[k]));
    end
    rxReadIdx = rxSeen.size();
    rxExp.delete();
  endtask

  initial begin
    logic       ack;
    logic [7:0] gExp;
    int         oenBefore;
    int         n;

    modelReset();
    repeat (4) @(negedge pclk);
    checkOutput("reset_sda_oen", 32'(sda_oen), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("reset_rx_ptr", 32'(rx_ptr), 32'd0);
    checkOutput("reset_rx_data", 32'(rx_data), 32'd0);
    areset = 1'b0;
    repeat (5) @(negedge pclk);

    $display("[TB] write ptr 3 data A5 5A");
    txQ = '{8'h03, 8'hA5, 8'h5A};
    writeTxn(OWN_ADDR);
    checkRx();

    $display("[TB] register-addressed read from 3");
    readTxn(8'h03, 2);

    $display("[TB] foreign address 0x51");
    oenBefore = oenCycles;
    txQ = '{8'h03, 8'h77};
    writeTxn(7'h51);
    checkOutput("foreign_no_pull", 32'(oenCycles), 32'(oenBefore));
    checkRx();

    $display("[TB] pointer wrap and truncation");
    txQ = '{8'h0F, 8'h11, 8'h22};
    writeTxn(OWN_ADDR);
    checkRx();
    readTxn(8'h0F, 2);
    readTxn(8'h13, 1);

    $display("[TB] randomized transfers");
    for (int t = 0; t < 4; t++) begin
      txQ.delete();
      txQ.push_back(8'($urandom_range(0, 255)));
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) txQ.push_back(8'($urandom_range(0, 255)));
      writeTxn(OWN_ADDR);
      checkRx();
    end
    for (int t = 0; t < 3; t++) begin
      readTxn(8'($urandom_range(0, 255)), $urandom_range(1, 4));
    end

    $display("[TB] reset during 5th data bit");
    busStart();
    writeByte({OWN_ADDR, 1'b0}, ack);
    writeByte(8'h05, ack);
    writeBit(1'b1);
    writeBit(1'b0);
    writeBit(1'b1);
    writeBit(1'b1);
    applyStimulus(1'b0, 1'b1, QTR);
    applyStimulus(1'b1, 1'b1, HALF / 2);
    checkOutput("pre_reset_busy", 32'(busy), 32'd1);
    areset = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    checkOutput("midreset_sda_oen", 32'(sda_oen), 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_rx_valid", 32'(rx_valid), 32'd0);
    areset = 1'b0;
    applyStimulus(1'b1, 1'b1, HALF);
    modelReset();
    checkRx();
    readTxn(8'h05, 1);
    txQ = '{8'h02, 8'h3C};
    writeTxn(OWN_ADDR);
    checkRx();
    readTxn(8'h02, 1);

    $display("[TB] SCL glitch during data bit");
`ifdef I2C_SLV_GLITCH_FILTER_EN
    gExp = 8'hA5;
`else
    gExp = glitchByte(8'hA5, 1);
`endif
    busStart();
    writeByte({OWN_ADDR, 1'b0}, ack);
    writeByte(8'h08, ack);
    writeByteGlitch(8'hA5, 1);
    busStop();
    refMem[8] = gExp;
    rxExp.push_back({4'd8, gExp});
    checkRx();
    readTxn(8'h08, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
